bus_fabric: RTL and testbench
=============================

# bus_fabric

Parametrised data-bus interconnect between the core's data port and NDEV memory-mapped devices (data BRAM, GPIO, terminal, …). It replaces per-device address decoders and the fixed two-way read mux. It adds multi-cycle read handshakes, posted writes, decode-error reporting and a read timeout. It sits between the core's mem_data_* port and the device instances in the toplevel.

## Interface
- NDEV, 4: number of device slots (1..16)
- DW, 32: data width
- DEV_BASE, NDEV×32 flattened: base address of slot i at [32i+:32]
- DEV_MASK, NDEV×5 flattened: count of offset bits k for slot i at [5i+:5]; slot i matches when addr[31:k]==base[31:k]
- TIMEOUT, 255: maximum WAIT cycles before a read is aborted (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- m_r_en  in  1  read request; the master holds it, with m_r_addr, while m_stall=1
- m_r_addr  in  32  read address
- m_r_data  out  DW  read data; valid when m_r_valid=1
- m_r_valid  out  1  one-cycle read completion pulse
- m_r_err  out  1  with m_r_valid: decode miss or timeout
- m_w_en, m_w_addr, m_w_data, m_w_mode  in  1/32/DW/2  write request (posted)
- m_w_err  out  1  one-cycle pulse: write hit no slot
- m_stall  out  1  master must freeze (drives the CMU clock_supress)
- dev_r_en  out  NDEV  one-hot read select
- dev_w_en  out  NDEV  one-hot write select
- dev_r_addr, dev_w_addr  out  32  address with bits ≥k cleared for the selected slot
- dev_w_data, dev_w_mode  out  DW/2  pass-through
- dev_r_data  in  NDEV×DW  per-slot read data
- dev_r_valid  in  NDEV  per-slot read-ready

## Operation
- Decode: the lowest matching index wins when slot ranges overlap. Decode is combinational on the address.
- Read FSM has three states: IDLE, WAIT, RESP.
  - IDLE/RESP with m_r_en and a hit: latch the slot and offset, then go to WAIT.
  - IDLE/RESP with m_r_en and a miss: go to RESP with m_r_err=1 and m_r_data=0.
  - WAIT: dev_r_en[slot]=1 and dev_r_addr is held from the latch.
    - dev_r_valid[slot]=1: register dev_r_data[slot] into m_r_data and go to RESP.
    - Timeout counter reaches TIMEOUT: go to RESP with m_r_err=1 and m_r_data=0.
  - RESP: m_r_valid=1 for one cycle. Return to IDLE, or accept a new read in the same cycle.
- dev_r_valid from unselected slots is ignored.
- Writes are posted. dev_w_en is combinational from m_w_en and decode, for one cycle, in any read state.
  - A write miss asserts m_w_err for one cycle in the following cycle; nothing is written.
  - A write in the same cycle as a read is issued immediately; the read proceeds independently.
- m_stall = (state==WAIT) | (m_r_en & state∈{IDLE,RESP}).
- The timeout counter is ceil(log2(TIMEOUT+1)) bits wide and clears on entering WAIT.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- rst asserted mid-read: in the next cycle the state is IDLE, dev_r_en=0 and no m_r_valid pulse occurs. A late dev_r_valid is ignored.
- Read latency, hit: request in cycle 0, dev_r_en from cycle 1.
  - dev_r_valid first seen in cycle n≥1 gives m_r_valid in cycle n+1.
  - Minimum latency is 2 cycles.
- Read latency, miss: m_r_valid with m_r_err in cycle 1.
- Read latency, timeout: m_r_valid with m_r_err in cycle TIMEOUT+1 after request.
- m_r_data holds its value until the next m_r_valid pulse.
- Writes: device sees dev_w_en in cycle 0 with zero latency; m_w_err appears in cycle 1.

## Structure
- Package bus_pkg holds: the read-state enum, MISS_DATA=0, and the function slot_match(addr, base, k).
- The toplevel builds the DEV_BASE/DEV_MASK vectors from constants in bus_pkg (GPIO0, TERM0, DATA).
- One sub-module is natural: bus_decode (comb), taking an address and returning hit, one-hot slot and offset. It is instanced twice, for the read and write paths.

## Test plan
Setup: NDEV=3, slots {0x10,k=4}, {0x50,k=4}, {0x1000,k=12}, TIMEOUT=8.
- Read 0x1008, slot 2 returns valid in cycle 1 with 0xCAFEF00D → dev_r_en=3'b100, dev_r_addr=0x008, m_r_valid in cycle 2, data 0xCAFEF00D, err=0, stall high for cycles 0–1.
- Read 0x14, slot 0 valid delayed to cycle 4 → m_r_valid in cycle 5; valid from slot 1 in cycle 2 is ignored.
- Read 0x2000 (miss) → m_r_valid and m_r_err in cycle 1, data 0; no dev_r_en. Write 0x2000 → no dev_w_en, m_w_err in cycle 1.
- Read 0x50, slot 1 never valid → m_r_err in cycle 9, data 0, FSM back to IDLE.
- Read 0x1000 pending while writing 0x58=0xAB → dev_w_en=3'b010 with dev_w_addr=0x8 in the same cycle; the read completes normally.
- rst pulsed in cycle 2 of a pending read → cycle 3 has dev_r_en=0 and m_stall=0; no m_r_valid ever appears.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the data-bus fabric.
//   - read-path state encoding (IDLE / WAIT / RESP)
//   - MISS_DATA: value returned on decode miss or timeout
//   - default device map (GPIO0, TERM0, DATA, GPIO1) used by bus_fabric
//   - slot_match / slot_offset: address decode helpers
package bus_pkg;

    typedef logic [1:0] rd_state_t;

    localparam rd_state_t RD_IDLE = 2'd0;
    localparam rd_state_t RD_WAIT = 2'd1;
    localparam rd_state_t RD_RESP = 2'd2;

    localparam int unsigned MISS_DATA = 0;

    // Default device map: base address and number of offset bits per slot.
    localparam logic [31:0] GPIO0_BASE = 32'h0000_0010;
    localparam logic [4:0]  GPIO0_BITS = 5'd4;
    localparam logic [31:0] TERM0_BASE = 32'h0000_0050;
    localparam logic [4:0]  TERM0_BITS = 5'd4;
    localparam logic [31:0] DATA_BASE  = 32'h0000_1000;
    localparam logic [4:0]  DATA_BITS  = 5'd12;
    localparam logic [31:0] GPIO1_BASE = 32'h0000_0020;
    localparam logic [4:0]  GPIO1_BITS = 5'd4;

    localparam int unsigned DEF_NDEV = 4;
    localparam logic [DEF_NDEV*32-1:0] DEF_BASE = {GPIO1_BASE, DATA_BASE, TERM0_BASE, GPIO0_BASE};
    localparam logic [DEF_NDEV*5-1:0]  DEF_MASK = {GPIO1_BITS, DATA_BITS, TERM0_BITS, GPIO0_BITS};

    // Slot matches when all address bits at or above k equal the base.
    function automatic logic slot_match(input logic [31:0] addr, input logic [31:0] base,
                                        input logic [4:0] k);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << k;
        return (addr & m) == (base & m);
    endfunction

    // Offset inside a slot: address with bits >= k cleared.
    function automatic logic [31:0] slot_offset(input logic [31:0] addr, input logic [4:0] k);
        return addr & ~(32'hFFFF_FFFF << k);
    endfunction

endpackage

// File: rtl/bus_decode.sv
// bus_decode: combinational address decoder.
//   i_addr   : address to decode
//   o_hit    : some slot matches
//   o_sel    : one-hot selected slot (lowest matching index wins)
//   o_offset : address with bits >= k cleared for the selected slot, 0 on miss
module bus_decode
    import bus_pkg::*;
#(
    parameter int unsigned          NDEV     = 4,
    parameter logic [NDEV*32-1:0]   DEV_BASE = '0,
    parameter logic [NDEV*5-1:0]    DEV_MASK = '0
) (
    input  logic [31:0]     i_addr,
    output logic            o_hit,
    output logic [NDEV-1:0] o_sel,
    output logic [31:0]     o_offset
);

    // Scan from the top so the lowest matching slot is written last.
    always_comb begin
        o_hit    = 1'b0;
        o_sel    = '0;
        o_offset = '0;
        for (int i = int'(NDEV) - 1; i >= 0; i--) begin
            if (slot_match(i_addr, DEV_BASE[32*i +: 32], DEV_MASK[5*i +: 5])) begin
                o_hit    = 1'b1;
                o_sel    = '0;
                o_sel[i] = 1'b1;
                o_offset = slot_offset(i_addr, DEV_MASK[5*i +: 5]);
            end
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// bus_fabric: data-bus interconnect between the core data port and NDEV devices.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_m_r_en/i_m_r_addr   : master read request (held while o_m_stall)
//   o_m_r_data/valid/err  : read completion (one-cycle valid, err on miss/timeout)
//   i_m_w_*               : posted write request; o_m_w_err pulses a cycle later on miss
//   o_m_stall             : master freeze
//   o_dev_r_en/o_dev_r_addr : one-hot read select and slot offset (held in WAIT)
//   o_dev_w_*             : one-hot write select, slot offset, data and mode
//   i_dev_r_data/valid    : per-slot read data and ready
module bus_fabric
    import bus_pkg::*;
#(
    parameter int unsigned          NDEV     = DEF_NDEV,
    parameter int unsigned          DW       = 32,
    parameter logic [NDEV*32-1:0]   DEV_BASE = DEF_BASE,
    parameter logic [NDEV*5-1:0]    DEV_MASK = DEF_MASK,
    parameter int unsigned          TIMEOUT  = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_m_r_en,
    input  logic [31:0]       i_m_r_addr,
    output logic [DW-1:0]     o_m_r_data,
    output logic              o_m_r_valid,
    output logic              o_m_r_err,
    input  logic              i_m_w_en,
    input  logic [31:0]       i_m_w_addr,
    input  logic [DW-1:0]     i_m_w_data,
    input  logic [1:0]        i_m_w_mode,
    output logic              o_m_w_err,
    output logic              o_m_stall,
    output logic [NDEV-1:0]   o_dev_r_en,
    output logic [NDEV-1:0]   o_dev_w_en,
    output logic [31:0]       o_dev_r_addr,
    output logic [31:0]       o_dev_w_addr,
    output logic [DW-1:0]     o_dev_w_data,
    output logic [1:0]        o_dev_w_mode,
    input  logic [NDEV*DW-1:0] i_dev_r_data,
    input  logic [NDEV-1:0]   i_dev_r_valid
);

    localparam int unsigned     CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TO_VAL = CW'(TIMEOUT);

    rd_state_t      r_state;
    rd_state_t      w_state_d;
    logic [NDEV-1:0] r_slot;
    logic [31:0]    r_addr;
    logic [CW-1:0]  r_cnt;
    logic [DW-1:0]  r_data;
    logic           r_err;
    logic           r_w_err;

    logic            w_r_hit;
    logic [NDEV-1:0] w_r_sel;
    logic [31:0]     w_r_offset;
    logic            w_w_hit;
    logic [NDEV-1:0] w_w_sel;
    logic [31:0]     w_w_offset;
    logic            w_dev_valid;
    logic [DW-1:0]   w_dev_data;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_timeout;
    logic            w_can_accept;

    bus_decode #(
        .NDEV     (NDEV),
        .DEV_BASE (DEV_BASE),
        .DEV_MASK (DEV_MASK)
    ) u_rd_decode (
        .i_addr   (i_m_r_addr),
        .o_hit    (w_r_hit),
        .o_sel    (w_r_sel),
        .o_offset (w_r_offset)
    );

    bus_decode #(
        .NDEV     (NDEV),
        .DEV_BASE (DEV_BASE),
        .DEV_MASK (DEV_MASK)
    ) u_wr_decode (
        .i_addr   (i_m_w_addr),
        .o_hit    (w_w_hit),
        .o_sel    (w_w_sel),
        .o_offset (w_w_offset)
    );

    // Only the latched slot's ready and data are looked at.
    always_comb begin
        w_dev_data = '0;
        for (int i = 0; i < int'(NDEV); i++) begin
            if (r_slot[i]) begin
                w_dev_data = w_dev_data | i_dev_r_data[DW*i +: DW];
            end
        end
    end

    assign w_dev_valid  = |(i_dev_r_valid & r_slot);
    assign w_cnt_inc    = r_cnt + 1'b1;
    assign w_timeout    = (w_cnt_inc == TO_VAL);
    assign w_can_accept = (r_state == RD_IDLE) || (r_state == RD_RESP);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            RD_IDLE, RD_RESP: begin
                w_state_d = RD_IDLE;
                if (i_m_r_en) begin
                    w_state_d = w_r_hit ? RD_WAIT : RD_RESP;
                end
            end
            RD_WAIT: begin
                if (w_dev_valid || w_timeout) begin
                    w_state_d = RD_RESP;
                end
            end
            default: w_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= RD_IDLE;
            r_slot  <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_w_err <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_w_err <= i_m_w_en & ~w_w_hit;
            if (w_can_accept) begin
                if (i_m_r_en) begin
                    if (w_r_hit) begin
                        r_slot <= w_r_sel;
                        r_addr <= w_r_offset;
                        r_cnt  <= '0;
                    end else begin
                        r_data <= DW'(MISS_DATA);
                        r_err  <= 1'b1;
                    end
                end
            end else if (r_state == RD_WAIT) begin
                r_cnt <= w_cnt_inc;
                // Device data beats the timeout when both land in the same cycle.
                if (w_dev_valid) begin
                    r_data <= w_dev_data;
                    r_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_data <= DW'(MISS_DATA);
                    r_err  <= 1'b1;
                end
            end
        end
    end

    assign o_m_r_data   = r_data;
    assign o_m_r_valid  = (r_state == RD_RESP);
    assign o_m_r_err    = r_err & (r_state == RD_RESP);
    assign o_m_w_err    = r_w_err;
    assign o_m_stall    = (r_state == RD_WAIT) | (i_m_r_en & w_can_accept);
    assign o_dev_r_en   = (r_state == RD_WAIT) ? r_slot : '0;
    assign o_dev_r_addr = r_addr;
    assign o_dev_w_en   = i_m_w_en ? w_w_sel : '0;
    assign o_dev_w_addr = i_m_w_en ? w_w_offset : '0;
    assign o_dev_w_data = i_m_w_data;
    assign o_dev_w_mode = i_m_w_mode;

endmodule

// File: tb/tb_bus_fabric.sv
// Bench for bus_fabric: per-cycle schedule of stimulus and expected outputs built
// up front from transaction-level rules, replayed against the DUT and compared.
module tb_bus_fabric;

    localparam int NDEV    = 3;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;
    localparam int NCYC    = 2600;

    localparam logic [NDEV*32-1:0] P_BASE = {32'h0000_1000, 32'h0000_0050, 32'h0000_0010};
    localparam logic [NDEV*5-1:0]  P_MASK = {5'd12, 5'd4, 5'd4};

    int unsigned m_base [NDEV] = '{32'h10, 32'h50, 32'h1000};
    int          m_bits [NDEV] = '{4, 4, 12};

    logic               clk = 1'b0;
    logic               rst;
    logic               m_r_en;
    logic [31:0]        m_r_addr;
    logic [DW-1:0]      m_r_data;
    logic               m_r_valid;
    logic               m_r_err;
    logic               m_w_en;
    logic [31:0]        m_w_addr;
    logic [DW-1:0]      m_w_data;
    logic [1:0]         m_w_mode;
    logic               m_w_err;
    logic               m_stall;
    logic [NDEV-1:0]    dev_r_en;
    logic [NDEV-1:0]    dev_w_en;
    logic [31:0]        dev_r_addr;
    logic [31:0]        dev_w_addr;
    logic [DW-1:0]      dev_w_data;
    logic [1:0]         dev_w_mode;
    logic [NDEV*DW-1:0] dev_r_data;
    logic [NDEV-1:0]    dev_r_valid;

    // Stimulus schedule
    bit              p_rst   [NCYC];
    bit              p_ren   [NCYC];
    bit [31:0]       p_raddr [NCYC];
    bit [NDEV-1:0]   p_valid [NCYC];
    bit [NDEV*DW-1:0] p_rdata [NCYC];
    bit              p_wen   [NCYC];
    bit [31:0]       p_waddr [NCYC];
    bit [DW-1:0]     p_wdata [NCYC];
    bit [1:0]        p_wmode [NCYC];

    // Expected outputs
    bit              e_rvalid [NCYC];
    bit              e_rerr   [NCYC];
    bit [DW-1:0]     e_rnew   [NCYC];
    bit [DW-1:0]     e_rdata  [NCYC];
    bit [NDEV-1:0]   e_ren    [NCYC];
    bit [31:0]       e_raddr  [NCYC];
    bit              e_stall  [NCYC];
    bit [NDEV-1:0]   e_wen    [NCYC];
    bit [31:0]       e_waddr  [NCYC];
    bit              e_werr   [NCYC];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit done = 1'b0;

    bus_fabric #(
        .NDEV     (NDEV),
        .DW       (DW),
        .DEV_BASE (P_BASE),
        .DEV_MASK (P_MASK),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_m_r_en      (m_r_en),
        .i_m_r_addr    (m_r_addr),
        .o_m_r_data    (m_r_data),
        .o_m_r_valid   (m_r_valid),
        .o_m_r_err     (m_r_err),
        .i_m_w_en      (m_w_en),
        .i_m_w_addr    (m_w_addr),
        .i_m_w_data    (m_w_data),
        .i_m_w_mode    (m_w_mode),
        .o_m_w_err     (m_w_err),
        .o_m_stall     (m_stall),
        .o_dev_r_en    (dev_r_en),
        .o_dev_w_en    (dev_w_en),
        .o_dev_r_addr  (dev_r_addr),
        .o_dev_w_addr  (dev_w_addr),
        .o_dev_w_data  (dev_w_data),
        .o_dev_w_mode  (dev_w_mode),
        .i_dev_r_data  (dev_r_data),
        .i_dev_r_valid (dev_r_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference decode: first slot whose address bits above k equal the base.
    function automatic void mdl_decode(input bit [31:0] a, output bit hit, output int idx,
                                       output bit [31:0] off);
        hit = 1'b0;
        idx = 0;
        off = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (!hit && ((a >> m_bits[i]) == (m_base[i] >> m_bits[i]))) begin
                hit = 1'b1;
                idx = i;
                off = a - ((a >> m_bits[i]) << m_bits[i]);
            end
        end
    endfunction

    function automatic bit [31:0] gen_addr();
        case ($urandom_range(0, 4))
            0:       return 32'h10 + $urandom_range(0, 15);
            1:       return 32'h50 + $urandom_range(0, 15);
            2:       return 32'h1000 + $urandom_range(0, 4095);
            3:       return 32'h2000 + $urandom_range(0, 255);
            default: return $urandom;
        endcase
    endfunction

    // A read issued at t whose device answers lat cycles later (lat > TIMEOUT: never).
    task automatic plan_read(input int t, input bit [31:0] addr, input int lat,
                             input bit [DW-1:0] dat, output int t_resp);
        bit hit;
        int idx;
        bit [31:0] off;
        int last;
        mdl_decode(addr, hit, idx, off);
        p_ren[t]   = 1'b1;
        p_raddr[t] = addr;
        e_stall[t] = 1'b1;
        if (!hit) begin
            t_resp = t + 1;
            e_rerr[t_resp] = 1'b1;
            e_rnew[t_resp] = '0;
        end else begin
            last = (lat <= TIMEOUT) ? t + lat : t + TIMEOUT;
            for (int c = t + 1; c <= last; c++) begin
                p_ren[c]        = 1'b1;
                p_raddr[c]      = addr;
                e_stall[c]      = 1'b1;
                e_ren[c]        = '0;
                e_ren[c][idx]   = 1'b1;
                e_raddr[c]      = off;
                p_valid[c][idx] = 1'b0;
            end
            t_resp = last + 1;
            if (lat <= TIMEOUT) begin
                p_valid[t + lat][idx] = 1'b1;
                p_rdata[t + lat][idx*DW +: DW] = dat;
                e_rnew[t_resp] = dat;
                e_rerr[t_resp] = 1'b0;
            end else begin
                e_rnew[t_resp] = '0;
                e_rerr[t_resp] = 1'b1;
            end
        end
        e_rvalid[t_resp] = 1'b1;
    endtask

    task automatic build_plan();
        int tr;
        int t;
        int lat;
        bit hit;
        int idx;
        bit [31:0] off;
        // Background device noise: random data and stray ready on every slot.
        for (int c = 0; c < NCYC; c++) begin
            p_valid[c] = NDEV'($urandom);
            for (int s = 0; s < NDEV; s++) p_rdata[c][s*DW +: DW] = $urandom;
        end
        p_rst[0] = 1'b1;
        p_rst[1] = 1'b1;

        plan_read(3, 32'h1008, 1, 32'hCAFE_F00D, tr);
        plan_read(7, 32'h14, 4, 32'h1234_5678, tr);
        p_valid[9][1] = 1'b1;
        plan_read(14, 32'h2000, 1, 32'h0, tr);
        p_wen[14] = 1'b1; p_waddr[14] = 32'h2000; p_wdata[14] = 32'h55; p_wmode[14] = 2'd1;
        plan_read(17, 32'h50, 100, 32'h0, tr);
        plan_read(28, 32'h1000, 3, 32'h0BAD_BEEF, tr);
        p_wen[29] = 1'b1; p_waddr[29] = 32'h58; p_wdata[29] = 32'hAB; p_wmode[29] = 2'd2;

        // Reset lands in the second WAIT cycle; the late ready must be ignored.
        for (int c = 34; c <= 36; c++) begin
            p_ren[c]   = 1'b1;
            p_raddr[c] = 32'h1000;
            e_stall[c] = 1'b1;
        end
        for (int c = 35; c <= 37; c++) p_valid[c][2] = 1'b0;
        e_ren[35] = 3'b100;
        e_ren[36] = 3'b100;
        p_rst[36] = 1'b1;
        p_valid[38][2] = 1'b1;

        for (int c = 42; c < NCYC - 2; c++) begin
            p_wen[c]   = ($urandom_range(0, 2) == 0);
            p_waddr[c] = gen_addr();
            p_wdata[c] = $urandom;
            p_wmode[c] = 2'($urandom);
        end
        t = 42;
        while (t < NCYC - 20) begin
            t += $urandom_range(0, 2);
            lat = ($urandom_range(0, 9) < 7) ? $urandom_range(1, TIMEOUT)
                                             : $urandom_range(TIMEOUT + 1, TIMEOUT + 4);
            plan_read(t, gen_addr(), lat, $urandom, tr);
            t = tr;
        end

        for (int c = 0; c < NCYC; c++) begin
            if (p_wen[c]) begin
                mdl_decode(p_waddr[c], hit, idx, off);
                if (hit) begin
                    e_wen[c][idx] = 1'b1;
                    e_waddr[c]    = off;
                end else if (c + 1 < NCYC && !p_rst[c]) begin
                    e_werr[c + 1] = 1'b1;
                end
            end
            if (c == 0)              e_rdata[c] = '0;
            else if (e_rvalid[c])    e_rdata[c] = e_rnew[c];
            else if (p_rst[c - 1])   e_rdata[c] = '0;
            else                     e_rdata[c] = e_rdata[c - 1];
        end
    endtask

    initial begin
        build_plan();
        // Hand-derived values pinning the schedule.
        chk("model hit dev_r_en", e_ren[4], 3'b100);
        chk("model hit dev_r_addr", e_raddr[4], 32'h8);
        chk("model hit stall c0", e_stall[3], 1'b1);
        chk("model hit data", {e_rvalid[5], e_rerr[5], e_rdata[5]}, {2'b10, 32'hCAFE_F00D});
        chk("model delayed valid", {e_rvalid[11], e_rvalid[12]}, 2'b01);
        chk("model miss resp", {e_rvalid[15], e_rerr[15], e_rdata[15]}, {2'b11, 32'h0});
        chk("model write miss err", {e_wen[14], e_werr[15]}, {3'b000, 1'b1});
        chk("model timeout resp", {e_rvalid[25], e_rvalid[26], e_rerr[26]}, 3'b011);
        chk("model write during read", {e_wen[29], e_waddr[29]}, {3'b010, 32'h8});
        chk("model reset read", {e_ren[36], e_ren[37], e_stall[37]}, {3'b100, 3'b000, 1'b0});

        for (int c = 0; c < NCYC; c++) begin
            cyc         = c;
            rst         = p_rst[c];
            m_r_en      = p_ren[c];
            m_r_addr    = p_raddr[c];
            m_w_en      = p_wen[c];
            m_w_addr    = p_waddr[c];
            m_w_data    = p_wdata[c];
            m_w_mode    = p_wmode[c];
            dev_r_valid = p_valid[c];
            dev_r_data  = p_rdata[c];
            @(posedge clk);
            #1;
        end
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    always @(negedge clk) begin
        if (!done && cyc >= 1) begin
            chk("m_r_valid", m_r_valid, e_rvalid[cyc]);
            if (e_rvalid[cyc]) chk("m_r_err", m_r_err, e_rerr[cyc]);
            chk("m_r_data", m_r_data, e_rdata[cyc]);
            chk("m_stall", m_stall, e_stall[cyc]);
            chk("dev_r_en", dev_r_en, e_ren[cyc]);
            if (e_ren[cyc] != '0) chk("dev_r_addr", dev_r_addr, e_raddr[cyc]);
            chk("dev_w_en", dev_w_en, e_wen[cyc]);
            if (e_wen[cyc] != '0) begin
                chk("dev_w_addr", dev_w_addr, e_waddr[cyc]);
                chk("dev_w_data", dev_w_data, p_wdata[cyc]);
                chk("dev_w_mode", dev_w_mode, p_wmode[cyc]);
            end
            chk("m_w_err", m_w_err, e_werr[cyc]);
        end
    end

endmodule
